// File: rtl/control_sequencer_pkg.sv
// Shared types and encodings for control_sequencer: FSM states, opcode map, ALU classes.
// Optional feature macro used by the top: CTRL_PERF_CNT_EN.
package control_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_MEND
  } state_e;

  typedef enum logic [2:0] {
    CLS_LW,
    CLS_SW,
    CLS_ALU,
    CLS_BEQ,
    CLS_BNE,
    CLS_J,
    CLS_ILL
  } op_class_e;

  localparam logic [3:0] OP_LW    = 4'b0000;
  localparam logic [3:0] OP_SW    = 4'b0001;
  localparam logic [3:0] OP_RTYPE = 4'b0010;
  localparam logic [3:0] OP_ADDI  = 4'b0011;
  localparam logic [3:0] OP_BEQ   = 4'b1011;
  localparam logic [3:0] OP_BNE   = 4'b1100;
  localparam logic [3:0] OP_J     = 4'b1101;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  // Classes whose instruction retires in EXEC.
  function automatic logic ends_in_exec(input op_class_e cls);
    return (cls == CLS_BEQ) || (cls == CLS_BNE) || (cls == CLS_J);
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Handshake/control bundle between run control, control_sequencer and Datapath_Unit.
interface control_sequencer_if #(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALU_OP_W = 2
);
  logic                start;
  logic                halt;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                ir_write;
  logic                pc_en;
  logic                jump;
  logic                beq;
  logic                bne;
  logic                mem_read;
  logic                mem_write;
  logic                alu_src;
  logic                reg_dst;
  logic                mem_to_reg;
  logic                reg_write;
  logic [ALU_OP_W-1:0] alu_op;
  logic                busy;
  logic                illegal_op;
  logic                mem_err;

  modport slave (
    input  start, halt, opcode, mem_ready,
    output ir_write, pc_en, jump, beq, bne, mem_read, mem_write,
           alu_src, reg_dst, mem_to_reg, reg_write, alu_op,
           busy, illegal_op, mem_err
  );

  modport master (
    output start, halt, opcode, mem_ready,
    input  ir_write, pc_en, jump, beq, bne, mem_read, mem_write,
           alu_src, reg_dst, mem_to_reg, reg_write, alu_op,
           busy, illegal_op, mem_err
  );
endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational opcode decoder: static datapath controls, instruction class, illegal flag.
module control_sequencer_decode
  import control_sequencer_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned ALU_OP_W = 2
) (
  input  logic [OPCODE_W-1:0] opcode_i,
  output logic                alu_src_o,
  output logic                reg_dst_o,
  output logic                mem_to_reg_o,
  output logic [ALU_OP_W-1:0] alu_op_o,
  output op_class_e           cls_o,
  output logic                illegal_o
);

  always_comb begin
    alu_src_o    = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_op_o     = '0;
    cls_o        = CLS_ILL;
    illegal_o    = 1'b1;
    case (opcode_i)
      OPCODE_W'(OP_LW): begin
        alu_src_o    = 1'b1;
        mem_to_reg_o = 1'b1;
        alu_op_o     = ALU_OP_W'(ALU_ADD);
        cls_o        = CLS_LW;
        illegal_o    = 1'b0;
      end
      OPCODE_W'(OP_SW): begin
        alu_src_o = 1'b1;
        alu_op_o  = ALU_OP_W'(ALU_ADD);
        cls_o     = CLS_SW;
        illegal_o = 1'b0;
      end
      OPCODE_W'(OP_RTYPE): begin
        reg_dst_o = 1'b1;
        alu_op_o  = ALU_OP_W'(ALU_FUNCT);
        cls_o     = CLS_ALU;
        illegal_o = 1'b0;
      end
      OPCODE_W'(OP_ADDI): begin
        alu_src_o = 1'b1;
        alu_op_o  = ALU_OP_W'(ALU_ADD);
        cls_o     = CLS_ALU;
        illegal_o = 1'b0;
      end
      OPCODE_W'(OP_BEQ): begin
        alu_op_o  = ALU_OP_W'(ALU_SUB);
        cls_o     = CLS_BEQ;
        illegal_o = 1'b0;
      end
      OPCODE_W'(OP_BNE): begin
        alu_op_o  = ALU_OP_W'(ALU_SUB);
        cls_o     = CLS_BNE;
        illegal_o = 1'b0;
      end
      OPCODE_W'(OP_J): begin
        cls_o     = CLS_J;
        illegal_o = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for Datapath_Unit, all outputs registered.
// `define CTRL_PERF_CNT_EN to add cycle_cnt_o / instr_cnt_o performance counters.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 4,
  parameter int unsigned ALU_OP_W    = 2,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned PERF_CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef CTRL_PERF_CNT_EN
  output logic [PERF_CNT_W-1:0] cycle_cnt_o,
  output logic [PERF_CNT_W-1:0] instr_cnt_o,
`endif
  control_sequencer_if.slave    bus
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || PERF_CNT_W < 1 || OPCODE_W < 4 || ALU_OP_W < 2)
  begin : g_param_check
    $error("control_sequencer: parameter out of range");
  end

  state_e              state_q, state_d, instr_end;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [7:0]          wait_q, wait_d;
  logic                abort_d;

  logic                dec_alu_src, dec_reg_dst, dec_mem_to_reg, dec_illegal;
  logic [ALU_OP_W-1:0] dec_alu_op;
  op_class_e           dec_cls;

  logic ir_write_q, pc_en_q, jump_q, beq_q, bne_q, mem_read_q, mem_write_q;
  logic alu_src_q, reg_dst_q, mem_to_reg_q, reg_write_q, busy_q, illegal_op_q, mem_err_q;
  logic ir_write_d, pc_en_d, jump_d, beq_d, bne_d, mem_read_d, mem_write_d;
  logic alu_src_d, reg_dst_d, mem_to_reg_d, reg_write_d, busy_d, illegal_op_d, mem_err_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic in_instr;

  // Decoding op_d lets the registered outputs of the DECODE cycle already reflect the new opcode.
  control_sequencer_decode #(
    .OPCODE_W (OPCODE_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_decode (
    .opcode_i     (op_d),
    .alu_src_o    (dec_alu_src),
    .reg_dst_o    (dec_reg_dst),
    .mem_to_reg_o (dec_mem_to_reg),
    .alu_op_o     (dec_alu_op),
    .cls_o        (dec_cls),
    .illegal_o    (dec_illegal)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wait_d    = wait_q;
    abort_d   = 1'b0;
    instr_end = bus.halt ? ST_IDLE : ST_FETCH;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_FETCH;
      ST_FETCH: begin
        op_d    = bus.opcode;
        state_d = ST_DECODE;
      end
      ST_DECODE: state_d = dec_illegal ? instr_end : ST_EXEC;
      ST_EXEC: begin
        case (dec_cls)
          CLS_LW, CLS_SW: begin
            state_d = ST_MEM;
            wait_d  = '0;
          end
          CLS_ALU: state_d = ST_WB;
          default: state_d = instr_end;
        endcase
      end
      ST_MEM: begin
        // A ready on the timeout cycle still completes normally.
        if (bus.mem_ready) begin
          state_d = (dec_cls == CLS_LW) ? ST_WB : ST_MEND;
        end else if (wait_q == 8'(MEM_TIMEOUT)) begin
          state_d = ST_MEND;
          abort_d = 1'b1;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WB, ST_MEND: state_d = instr_end;
      default:        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_instr     = (state_d == ST_DECODE) || (state_d == ST_EXEC) || (state_d == ST_MEM) ||
                   (state_d == ST_WB) || (state_d == ST_MEND);
    ir_write_d   = (state_d == ST_FETCH);
    busy_d       = (state_d != ST_IDLE);
    alu_src_d    = in_instr && dec_alu_src;
    reg_dst_d    = in_instr && dec_reg_dst;
    mem_to_reg_d = in_instr && dec_mem_to_reg;
    alu_op_d     = in_instr ? dec_alu_op : '0;
    illegal_op_d = (state_d == ST_DECODE) && dec_illegal;
    beq_d        = (state_d == ST_EXEC) && (dec_cls == CLS_BEQ);
    bne_d        = (state_d == ST_EXEC) && (dec_cls == CLS_BNE);
    jump_d       = (state_d == ST_EXEC) && (dec_cls == CLS_J);
    mem_read_d   = (state_d == ST_MEM) && (dec_cls == CLS_LW);
    mem_write_d  = (state_d == ST_MEM) && (dec_cls == CLS_SW);
    reg_write_d  = (state_d == ST_WB);
    mem_err_d    = abort_d;
    pc_en_d      = illegal_op_d || ((state_d == ST_EXEC) && ends_in_exec(dec_cls)) ||
                   (state_d == ST_WB) || (state_d == ST_MEND);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= '0;
      wait_q       <= '0;
      ir_write_q   <= 1'b0;
      pc_en_q      <= 1'b0;
      jump_q       <= 1'b0;
      beq_q        <= 1'b0;
      bne_q        <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_op_q     <= '0;
      busy_q       <= 1'b0;
      illegal_op_q <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      wait_q       <= wait_d;
      ir_write_q   <= ir_write_d;
      pc_en_q      <= pc_en_d;
      jump_q       <= jump_d;
      beq_q        <= beq_d;
      bne_q        <= bne_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      alu_src_q    <= alu_src_d;
      reg_dst_q    <= reg_dst_d;
      mem_to_reg_q <= mem_to_reg_d;
      reg_write_q  <= reg_write_d;
      alu_op_q     <= alu_op_d;
      busy_q       <= busy_d;
      illegal_op_q <= illegal_op_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign bus.ir_write   = ir_write_q;
  assign bus.pc_en      = pc_en_q;
  assign bus.jump       = jump_q;
  assign bus.beq        = beq_q;
  assign bus.bne        = bne_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.alu_src    = alu_src_q;
  assign bus.reg_dst    = reg_dst_q;
  assign bus.mem_to_reg = mem_to_reg_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.busy       = busy_q;
  assign bus.illegal_op = illegal_op_q;
  assign bus.mem_err    = mem_err_q;

`ifdef CTRL_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (busy_q)  cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (pc_en_q) instr_cnt_q <= instr_cnt_q + 1'b1;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;
`else
  // Performance counters not built.
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: vector table, corner sequences, randomized run vs trace model.
module tb_control_sequencer;

  localparam int TMO = 15;

  typedef struct packed {
    logic       ir_write, pc_en, jump, beq, bne, mem_read, mem_write;
    logic       alu_src, reg_dst, mem_to_reg, reg_write;
    logic [1:0] alu_op;
    logic       busy, illegal_op, mem_err;
  } outv_t;

  typedef struct {
    string      name;
    logic [3:0] op;
    int         w;
    int         exp_cyc;
    logic       exp_err;
    logic       exp_ill;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  outv_t exp_q[$];

  control_sequencer_if #(.OPCODE_W(4), .ALU_OP_W(2)) bus ();

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
  control_sequencer #(.OPCODE_W(4), .ALU_OP_W(2), .MEM_TIMEOUT(TMO), .PERF_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cycle_cnt_o(cycle_cnt), .instr_cnt_o(instr_cnt), .bus(bus));
`else
  control_sequencer #(.OPCODE_W(4), .ALU_OP_W(2), .MEM_TIMEOUT(TMO), .PERF_CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic outv_t sample();
    outv_t o;
    o.ir_write   = bus.ir_write;
    o.pc_en      = bus.pc_en;
    o.jump       = bus.jump;
    o.beq        = bus.beq;
    o.bne        = bus.bne;
    o.mem_read   = bus.mem_read;
    o.mem_write  = bus.mem_write;
    o.alu_src    = bus.alu_src;
    o.reg_dst    = bus.reg_dst;
    o.mem_to_reg = bus.mem_to_reg;
    o.reg_write  = bus.reg_write;
    o.alu_op     = bus.alu_op;
    o.busy       = bus.busy;
    o.illegal_op = bus.illegal_op;
    o.mem_err    = bus.mem_err;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Expected per-cycle outputs of one instruction, FETCH to its pc_en cycle.
  function automatic void build_trace(input logic [3:0] op, input int w);
    outv_t c, f, e;
    string k;
    int    n;
    exp_q.delete();
    c = '0;
    c.busy = 1'b1;
    k = "ILL";
    case (op)
      4'b0000: begin k = "LW";  c.alu_src = 1'b1; c.mem_to_reg = 1'b1; end
      4'b0001: begin k = "SW";  c.alu_src = 1'b1; end
      4'b0010: begin k = "ALU"; c.reg_dst = 1'b1; c.alu_op = 2'b10; end
      4'b0011: begin k = "ALU"; c.alu_src = 1'b1; end
      4'b1011: begin k = "BEQ"; c.alu_op = 2'b01; end
      4'b1100: begin k = "BNE"; c.alu_op = 2'b01; end
      4'b1101: k = "J";
      default: ;
    endcase
    f = '0;
    f.busy = 1'b1;
    f.ir_write = 1'b1;
    exp_q.push_back(f);
    if (k == "ILL") begin
      e = '0;
      e.busy = 1'b1;
      e.illegal_op = 1'b1;
      e.pc_en = 1'b1;
      exp_q.push_back(e);
      return;
    end
    exp_q.push_back(c);
    e = c;
    e.pc_en = 1'b1;
    if (k == "BEQ" || k == "BNE" || k == "J") begin
      e.beq  = (k == "BEQ");
      e.bne  = (k == "BNE");
      e.jump = (k == "J");
      exp_q.push_back(e);
      return;
    end
    exp_q.push_back(c);
    if (k == "ALU") begin
      e.reg_write = 1'b1;
      exp_q.push_back(e);
      return;
    end
    n = (w > TMO) ? TMO + 1 : w + 1;
    f = c;
    f.mem_read  = (k == "LW");
    f.mem_write = (k == "SW");
    repeat (n) exp_q.push_back(f);
    if (w > TMO) e.mem_err = 1'b1;
    else if (k == "LW") e.reg_write = 1'b1;
    exp_q.push_back(e);
  endfunction

  // Runs one instruction. Entry/exit at #1 after an edge; memory answers after w wait cycles.
  task automatic exec_instr(input logic [3:0] op, input int w, input logic h, input logic from_idle,
                            input string tag, output int cyc, output logic saw_err,
                            output logic saw_ill);
    outv_t got;
    int    j;
    build_trace(op, w);
    bus.opcode = op;
    if (from_idle) bus.start = 1'b1;
    j = 0;
    cyc = 0;
    saw_err = 1'b0;
    saw_ill = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'($urandom_range(0, 1));
      got = sample();
      chk($sformatf("%s_c%0d", tag, i + 1), 32'(got), 32'(exp_q[i]));
      if (got.pc_en && cyc == 0) cyc = i + 1;
      saw_err |= got.mem_err;
      saw_ill |= got.illegal_op;
      if (exp_q[i].mem_read || exp_q[i].mem_write) begin
        bus.mem_ready = (j == w);
        j++;
      end else begin
        bus.mem_ready = 1'b0;
      end
      bus.halt = (i == exp_q.size() - 1) ? h : 1'($urandom_range(0, 1));
    end
    if (h) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.mem_ready = 1'b0;
      chk({tag, "_idle"}, 32'(sample()), 32'(0));
    end
  endtask

  initial begin
    vec_t  tbl[12];
    int    cyc, cyc2;
    logic  e, il;
    logic  idle;
    logic [3:0] legal[7];
    logic [3:0] op;
    int    w;
    logic  h;
    outv_t fv;

    tbl[0]  = '{"rtype",     4'b0010, 0,  4,  1'b0, 1'b0};
    tbl[1]  = '{"addi",      4'b0011, 0,  4,  1'b0, 1'b0};
    tbl[2]  = '{"lw_w3",     4'b0000, 3,  8,  1'b0, 1'b0};
    tbl[3]  = '{"lw_w15",    4'b0000, 15, 20, 1'b0, 1'b0};
    tbl[4]  = '{"lw_tmo",    4'b0000, 16, 20, 1'b1, 1'b0};
    tbl[5]  = '{"sw_w2",     4'b0001, 2,  7,  1'b0, 1'b0};
    tbl[6]  = '{"sw_tmo",    4'b0001, 99, 20, 1'b1, 1'b0};
    tbl[7]  = '{"beq",       4'b1011, 0,  3,  1'b0, 1'b0};
    tbl[8]  = '{"bne",       4'b1100, 0,  3,  1'b0, 1'b0};
    tbl[9]  = '{"j",         4'b1101, 0,  3,  1'b0, 1'b0};
    tbl[10] = '{"ill_1111",  4'b1111, 0,  2,  1'b0, 1'b1};
    tbl[11] = '{"ill_0100",  4'b0100, 0,  2,  1'b0, 1'b1};
    legal = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1011, 4'b1100, 4'b1101};

    bus.start = 1'b0;
    bus.halt = 1'b0;
    bus.opcode = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(sample()), 32'(0));
`ifdef CTRL_PERF_CNT_EN
    chk("reset_cycle_cnt", cycle_cnt, 0);
    chk("reset_instr_cnt", instr_cnt, 0);
`endif
    rst_n = 1'b1;

    for (int t = 0; t < 12; t++) begin
`ifdef CTRL_PERF_CNT_EN
      cyc2 = int'(instr_cnt);
`endif
      exec_instr(tbl[t].op, tbl[t].w, 1'b1, 1'b1, tbl[t].name, cyc, e, il);
      chk({tbl[t].name, "_cycles"}, 32'(cyc), 32'(tbl[t].exp_cyc));
      chk({tbl[t].name, "_mem_err"}, 32'(e), 32'(tbl[t].exp_err));
      chk({tbl[t].name, "_illegal"}, 32'(il), 32'(tbl[t].exp_ill));
`ifdef CTRL_PERF_CNT_EN
      chk({tbl[t].name, "_instr_cnt"}, instr_cnt, 32'(cyc2 + 1));
`endif
    end

    // BEQ then J back to back: second pc_en lands on cycle 6.
    exec_instr(4'b1011, 0, 1'b0, 1'b1, "seq_beq", cyc, e, il);
    exec_instr(4'b1101, 0, 1'b1, 1'b0, "seq_j", cyc2, e, il);
    chk("seq_beq_j_pc_en_cycle", 32'(cyc + cyc2), 32'(6));

    // Asynchronous reset in the middle of a memory wait.
    bus.opcode = 4'b0000;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_mem_read", 32'(bus.mem_read), 32'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 32'(sample()), 32'(0));
    #2;
    rst_n = 1'b1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    fv = '0;
    fv.ir_write = 1'b1;
    fv.busy = 1'b1;
    chk("post_rst_fetch", 32'(sample()), 32'(fv));
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(sample()), 32'(0));

    idle = 1'b1;
    for (int n = 0; n < 80; n++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : legal[$urandom_range(0, 6)];
      w  = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4);
      h  = ($urandom_range(0, 3) == 0);
      exec_instr(op, w, h, idle, $sformatf("rnd%0d_op%h", n, op), cyc, e, il);
      idle = h;
    end
    if (!idle) exec_instr(4'b0010, 0, 1'b1, 1'b0, "rnd_tail", cyc, e, il);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
